// File: rtl/seven_seg_scan_decoder_if.sv
// Display bus as seen by the scan decoder: raw anode/segment lines in,
// reconstructed digit values and one-cycle event pulses out.
interface seven_seg_scan_decoder_if #(
  parameter int NUM_DIGITS = 4
);
  logic [NUM_DIGITS-1:0]   an;
  logic [7:0]              sseg;
  logic [4*NUM_DIGITS-1:0] hex_value;
  logic [NUM_DIGITS-1:0]   dp_value;
  logic [NUM_DIGITS-1:0]   digit_valid;
  logic                    frame_valid;
  logic                    pattern_err;
  logic                    multi_an_err;

  modport master (
    output an, sseg,
    input  hex_value, dp_value, digit_valid, frame_valid, pattern_err, multi_an_err
  );

  modport slave (
    input  an, sseg,
    output hex_value, dp_value, digit_valid, frame_valid, pattern_err, multi_an_err
  );
endinterface

// File: rtl/seven_seg_scan_decoder.sv
// Loopback reader for a multiplexed active-low seven-segment bus: synchronizes,
// waits for a stable sample, then maps the glyph back to a nibble per digit.
module seven_seg_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  seven_seg_scan_decoder_if.slave bus
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int LW = $clog2(NUM_DIGITS + 1);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CAP_AT  = CW'(STABLE_CYCLES - 1);

  logic [NUM_DIGITS-1:0]   s1_an_q, s2_an_q;
  logic [7:0]              s1_seg_q, s2_seg_q;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] hex_q, hex_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic                    frame_q, frame_d;
  logic                    pat_err_q, pat_err_d;
  logic                    multi_q, multi_d;

  logic          same;
  logic          capture;
  logic [LW-1:0] low_cnt;
  logic [IW-1:0] digit_idx;
  logic          glyph_hit;
  logic [3:0]    glyph_nib;
  logic          blank;

  assign same    = ({s1_an_q, s1_seg_q} == {s2_an_q, s2_seg_q});
  // Saturation at STABLE_CYCLES keeps a held pattern from being captured twice.
  assign capture = same && (cnt_q == CAP_AT);
  assign blank   = (s2_seg_q[6:0] == 7'h7F);

  always_comb begin
    cnt_d = '0;
    if (same) cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CW'(1);
  end

  always_comb begin
    low_cnt   = '0;
    digit_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!s2_an_q[i]) begin
        low_cnt   = low_cnt + LW'(1);
        digit_idx = IW'(i);
      end
    end
  end

  always_comb begin
    glyph_hit = 1'b1;
    glyph_nib = 4'h0;
    case (s2_seg_q[6:0])
      7'h40: glyph_nib = 4'h0;
      7'h79: glyph_nib = 4'h1;
      7'h24: glyph_nib = 4'h2;
      7'h30: glyph_nib = 4'h3;
      7'h19: glyph_nib = 4'h4;
      7'h12: glyph_nib = 4'h5;
      7'h02: glyph_nib = 4'h6;
      7'h78: glyph_nib = 4'h7;
      7'h00: glyph_nib = 4'h8;
      7'h18: glyph_nib = 4'h9;
      7'h08: glyph_nib = 4'hA;
      7'h03: glyph_nib = 4'hB;
      7'h46: glyph_nib = 4'hC;
      7'h21: glyph_nib = 4'hD;
      7'h06: glyph_nib = 4'hE;
      7'h0E: glyph_nib = 4'hF;
      default: glyph_hit = 1'b0;
    endcase
  end

  always_comb begin
    hex_d     = hex_q;
    dp_d      = dp_q;
    valid_d   = valid_q;
    frame_d   = &seen_q;
    seen_d    = (&seen_q) ? '0 : seen_q;
    pat_err_d = 1'b0;
    multi_d   = 1'b0;
    // Capture is applied after the frame clear so a same-edge capture survives it.
    if (capture) begin
      if (low_cnt > LW'(1)) begin
        multi_d = 1'b1;
      end else if (low_cnt == LW'(1)) begin
        if (glyph_hit) begin
          hex_d[4*digit_idx +: 4] = glyph_nib;
          dp_d[digit_idx]         = s2_seg_q[7];
          valid_d[digit_idx]      = 1'b1;
          seen_d[digit_idx]       = 1'b1;
        end else if (blank) begin
          valid_d[digit_idx] = 1'b0;
          seen_d[digit_idx]  = 1'b1;
        end else begin
          pat_err_d          = 1'b1;
          valid_d[digit_idx] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_an_q   <= '1;
      s2_an_q   <= '1;
      s1_seg_q  <= '1;
      s2_seg_q  <= '1;
      cnt_q     <= '0;
      hex_q     <= '0;
      dp_q      <= '0;
      valid_q   <= '0;
      seen_q    <= '0;
      frame_q   <= 1'b0;
      pat_err_q <= 1'b0;
      multi_q   <= 1'b0;
    end else begin
      s1_an_q   <= bus.an;
      s2_an_q   <= s1_an_q;
      s1_seg_q  <= bus.sseg;
      s2_seg_q  <= s1_seg_q;
      cnt_q     <= cnt_d;
      hex_q     <= hex_d;
      dp_q      <= dp_d;
      valid_q   <= valid_d;
      seen_q    <= seen_d;
      frame_q   <= frame_d;
      pat_err_q <= pat_err_d;
      multi_q   <= multi_d;
    end
  end

  assign bus.hex_value    = hex_q;
  assign bus.dp_value     = dp_q;
  assign bus.digit_valid  = valid_q;
  assign bus.frame_valid  = frame_q;
  assign bus.pattern_err  = pat_err_q;
  assign bus.multi_an_err = multi_q;
endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Randomized and directed bench for the seven-segment scan decoder, checked
// against a per-hold behavioural model of what the display reader should see.
module tb_seven_seg_scan_decoder;
  localparam int ND = 4;
  localparam int SC = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seven_seg_scan_decoder_if #(.NUM_DIGITS(ND)) bus ();

  seven_seg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: what the reader should hold after each stable hold.
  logic [3:0]      m_hex [ND];
  logic [ND-1:0]   m_dp, m_valid, m_seen;
  logic [ND+7:0]   prev_in;
  logic [4*ND-1:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int glyph_of(input logic [6:0] c);
    for (int v = 0; v < 16; v++) if (seg_tab[v] == c) return v;
    if (c == 7'h7F) return -1;
    return -2;
  endfunction

  function automatic logic [4*ND-1:0] model_hex();
    logic [4*ND-1:0] r;
    for (int i = 0; i < ND; i++) r[4*i +: 4] = m_hex[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ND; i++) m_hex[i] = 4'h0;
    m_dp = '0; m_valid = '0; m_seen = '0;
    prev_in = '1;
  endtask

  // Hold one (an, sseg) pattern for h edges; h >= SC+3 or h <= SC so that
  // every event from a captured hold lands inside its own observation window.
  task automatic step(input logic [ND-1:0] a, input logic [7:0] s, input int h);
    int n_fv, n_pe, n_ma, fv_at, pe_at, ma_at, upd_at;
    int e_fv, e_pe, e_ma, e_upd, lows, idx, g;
    logic [4*ND-1:0] h0;
    logic [ND-1:0]   d0, v0;
    logic [4*ND-1:0] got_hex;
    n_fv = 0; n_pe = 0; n_ma = 0; fv_at = 0; pe_at = 0; ma_at = 0; upd_at = 0;
    e_fv = 0; e_pe = 0; e_ma = 0; e_upd = 0;
    h0 = bus.hex_value; d0 = bus.dp_value; v0 = bus.digit_valid;
    bus.an = a; bus.sseg = s;
    prev_in = {a, s};
    for (int j = 1; j <= h; j++) begin
      @(posedge clk); #1;
      if (bus.frame_valid)  begin n_fv++; fv_at = j; end
      if (bus.pattern_err)  begin n_pe++; pe_at = j; end
      if (bus.multi_an_err) begin n_ma++; ma_at = j; end
      if (upd_at == 0 && {bus.hex_value, bus.dp_value, bus.digit_valid} != {h0, d0, v0}) upd_at = j;
    end
    if (h >= SC + 1) begin
      lows = $countones(~a);
      idx = 0;
      for (int i = 0; i < ND; i++) if (!a[i]) idx = i;
      if (lows > 1) begin
        e_ma = 1;
      end else if (lows == 1) begin
        g = glyph_of(s[6:0]);
        if (g >= 0) begin
          m_hex[idx] = 4'(g); m_dp[idx] = s[7]; m_valid[idx] = 1'b1; m_seen[idx] = 1'b1;
        end else if (g == -1) begin
          m_valid[idx] = 1'b0; m_seen[idx] = 1'b1;
        end else begin
          e_pe = 1; m_valid[idx] = 1'b0;
        end
      end
      if (&m_seen) begin e_fv = 1; m_seen = '0; end
    end
    if ({model_hex(), m_dp, m_valid} != {h0, d0, v0}) e_upd = SC + 2;
    check("frame_valid_count", 32'(n_fv), 32'(e_fv));
    check("pattern_err_count", 32'(n_pe), 32'(e_pe));
    check("multi_an_err_count", 32'(n_ma), 32'(e_ma));
    if (e_fv != 0) check("frame_valid_cycle", 32'(fv_at), 32'(SC + 3));
    if (e_pe != 0) check("pattern_err_cycle", 32'(pe_at), 32'(SC + 2));
    if (e_ma != 0) check("multi_an_err_cycle", 32'(ma_at), 32'(SC + 2));
    check("capture_latency", 32'(upd_at), 32'(e_upd));
    exp_q.push_back(model_hex());
    got_hex = bus.hex_value;
    check("hex_value", 32'(got_hex), 32'(exp_q.pop_front()));
    check("dp_value", 32'(bus.dp_value), 32'(m_dp));
    check("digit_valid", 32'(bus.digit_valid), 32'(m_valid));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_hex"},   32'(bus.hex_value), 32'h0);
    check({tag, "_dp"},    32'(bus.dp_value), 32'h0);
    check({tag, "_valid"}, 32'(bus.digit_valid), 32'h0);
    check({tag, "_pulses"}, {29'h0, bus.frame_valid, bus.pattern_err, bus.multi_an_err}, 32'h0);
  endtask

  task automatic rand_step();
    logic [ND-1:0] a;
    logic [7:0]    s;
    int r, h;
    do begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = '1;
      else if (r == 1) a = ND'($urandom) & ~ND'(3);
      else             a = ~(ND'(1) << $urandom_range(0, ND - 1));
      r = $urandom_range(0, 9);
      if (r == 0)      s = {1'($urandom), 7'h7F};
      else if (r == 1) s = 8'($urandom);
      else             s = {1'($urandom), seg_tab[$urandom_range(0, 15)]};
    end while ({a, s} == prev_in);
    h = ($urandom_range(0, 5) == 0) ? $urandom_range(1, SC) : $urandom_range(SC + 3, SC + 8);
    step(a, s, h);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.an = '1;
    bus.sseg = '1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single digit, then glitch rejection on digit 1
    step(4'b1110, 8'hA4, 10);
    check("single_digit_hex0", 32'(bus.hex_value[3:0]), 32'h2);
    step(4'b1101, 8'h79, 3);
    step(4'b1101, 8'h24, 8);

    // Full frame showing 4321
    step(4'b1110, 8'h79, 8);
    step(4'b1101, 8'h24, 8);
    step(4'b1011, 8'h30, 8);
    step(4'b0111, 8'h19, 8);
    check("full_frame_hex", 32'(bus.hex_value), 32'h4321);
    check("full_frame_valid", 32'(bus.digit_valid), 32'hF);

    // Illegal then blank glyph on digit 1, then two anodes low
    step(4'b1101, 8'h7E, 9);
    step(4'b1101, 8'h7F, 9);
    step(4'b1100, 8'h00, 9);

    for (int n = 0; n < 60; n++) rand_step();

    // Reset partway through a frame
    step(4'b1110, 8'h12, 8);
    step(4'b1101, 8'h02, 8);
    step(4'b1011, 8'h78, 8);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    bus.an = '1;
    bus.sseg = '1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    step(4'b0111, 8'h00, 9);
    step(4'b0111, 8'h8E, 9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/seven_seg_scan_decoder.md
# seven_seg_scan_decoder

Monitors a multiplexed, active-low seven-segment display bus and reconstructs the hex value shown on each digit. It is the inverse of the hex-to-segment encoder used by the display path. It samples the anode and segment lines, waits for them to hold steady, then maps each glyph back to its 4-bit nibble and decimal-point state. It sits beside the display driver as a loopback and self-check reader, so the CPU and the test benches can confirm what the display is actually showing.

## Interface
- NUM_DIGITS, 4: number of multiplexed digits and the width of `an`.
- STABLE_CYCLES, 4: consecutive unchanged samples required before a capture, minimum 2.

- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- an  in  NUM_DIGITS  anode enables, active-low; bit i selects digit i; asynchronous to clk.
- sseg  in  8  segment bus, asynchronous to clk:
  - bits [6:0] are segments a..g, active-low (0 = lit);
  - bit 7 is dp, passed through raw.
- hex_value  out  4*NUM_DIGITS  decoded nibbles; digit i occupies [4i+3:4i].
- dp_value  out  NUM_DIGITS  captured dp bit per digit.
- digit_valid  out  NUM_DIGITS  1 when the last capture for that digit was a legal glyph.
- frame_valid  out  1  one-cycle pulse when every digit has been captured since the previous pulse.
- pattern_err  out  1  one-cycle pulse when an illegal glyph is captured.
- multi_an_err  out  1  one-cycle pulse when a stable sample has more than one anode low.

## Operation
- Synchronizer:
  - `an` and `sseg` each pass through a 2-flop synchronizer (s1, s2).
  - Both flops reset to all-ones: anodes inactive, segments dark, dp=1.
- Stability counter:
  - On each edge, if s1==s2 (all NUM_DIGITS+8 bits), cnt increments and saturates at STABLE_CYCLES; otherwise cnt clears to 0.
- Capture event:
  - Fires on the edge where cnt==STABLE_CYCLES-1 and s1==s2.
  - Fires exactly once per stable period; it cannot fire again until the inputs change.
- Action at a capture event, based on s2 `an`:
  - No anode low: no action.
  - More than one anode low: pulse multi_an_err; no register updates.
  - Exactly one anode low (index i): decode s2 `sseg[6:0]` as below.
- Glyph decode for digit i, segment code to nibble: 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 18→9, 08→A, 03→b, 46→C, 21→d, 06→E, 0E→F.
  - Match: hex nibble i ← decoded value; dp_value[i] ← sseg[7]; digit_valid[i] ← 1; seen[i] ← 1.
  - Blank (7F): digit_valid[i] ← 0; seen[i] ← 1; nibble unchanged; no error.
  - Any other code: pattern_err pulses; digit_valid[i] ← 0; nibble and dp unchanged; seen[i] unchanged.
- Frame completion:
  - When seen becomes all-ones, frame_valid pulses on the next edge and seen clears on that same edge.
  - A capture on that same edge sets its seen bit after the clear.
- Reset:
  - rst_n low immediately clears hex_value, dp_value, digit_valid, seen, cnt and all pulse outputs to 0, and sets the synchronizers to all-ones.
  - Asserting reset mid-frame discards partial progress.

## Timing
- Input latency: inputs change before edge k and then hold. s1 updates at edge k and s2 at edge k+1; cnt reaches 1 at edge k+2.
- Capture latency: captured outputs update at edge k+STABLE_CYCLES+1, which is edge k+5 at the default.
- Pulse outputs:
  - pattern_err and multi_an_err are registered and assert on the capture edge, high for exactly 1 cycle.
  - frame_valid is high for the cycle after the edge on which seen becomes all-ones.
- Glitch rejection: any change before the capture edge restarts the count, so inputs stable for fewer than STABLE_CYCLES+1 edges are never captured.
- Throughput: a scan period of at least STABLE_CYCLES+3 clk cycles per digit is required for every digit to be captured.

## Test plan
- Single digit:
  - Stimulus: an=1110, sseg=A4 (dp=1, glyph 2) applied before edge k and held 10 cycles.
  - Response: at edge k+5, hex_value[3:0]=2, dp_value[0]=1, digit_valid[0]=1; no error pulses; one capture only.
- Glitch:
  - Stimulus: an=1101, sseg=79 held for 3 edges, then sseg=24 held.
  - Response: no capture of 1; digit 1 captures 2 five edges after the change.
- Full frame:
  - Stimulus: digits 0..3 show 1, 2, 3, 4 (sseg 79, 24, 30, 19), each held 8 cycles.
  - Response: hex_value=4321; digit_valid=1111; exactly one frame_valid pulse, one cycle after digit 3 is captured.
- Illegal and blank glyphs:
  - Stimulus: digit 1 shows 7E, then 7F.
  - Response for 7E: one pattern_err pulse; digit_valid[1]=0; nibble 1 unchanged.
  - Response for 7F: digit_valid[1]=0 and no pattern_err.
- Multiple anodes:
  - Stimulus: an=1100, sseg=00 held.
  - Response: one multi_an_err pulse; hex_value, digit_valid and seen unchanged.
- Reset mid-frame:
  - Stimulus: rst_n low after digits 0..2 are captured.
  - Response: all outputs are 0 immediately. After release, a capture of digit 3 alone produces no frame_valid.
